// File: rtl/de_pipe_reg.sv
// Decode->Execute pipeline register with load-use/tnew-tuse stall detection and bubble insertion.
// Optional saturating stall counter output when DE_STALL_CNT_EN is defined.
module de_pipe_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext,
    input  logic        D_RfWr,
    input  logic        D_DMWr,
    input  logic [2:0]  D_ALUOp,
    input  logic [2:0]  D_Src_ALU_B,
    input  logic [1:0]  D_RF_WD_type,
    input  logic [2:0]  D_load_type,
    input  logic [2:0]  D_store_type,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic [1:0]  D_E_tnew,
    input  logic        D_lwtt,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_tnew,
    input  logic        M_lwtt,
    output logic        stall,
    output logic [31:0] E_instr,
    output logic [31:0] E_pc,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_ext,
    output logic        E_RfWr,
    output logic        E_DMWr,
    output logic [2:0]  E_ALUOp,
    output logic [2:0]  E_Src_ALU_B,
    output logic [1:0]  E_RF_WD_type,
    output logic [2:0]  E_load_type,
    output logic [2:0]  E_store_type,
    output logic [4:0]  E_A1,
    output logic [4:0]  E_A2,
    output logic [4:0]  E_A3,
    output logic [1:0]  E_tnew,
    output logic        E_lwtt,
    output logic        E_valid
`ifdef DE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] ext;
        logic        rf_wr;
        logic        dm_wr;
        logic [2:0]  alu_op;
        logic [2:0]  src_alu_b;
        logic [1:0]  rf_wd_type;
        logic [2:0]  load_type;
        logic [2:0]  store_type;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic        lwtt;
        logic        valid;
    } e_reg_t;

    e_reg_t e_q, e_d;

    // A producer with an unresolved destination (lwtt) conservatively matches any nonzero source.
    function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] dst, input logic [1:0] tnew,
                                    input logic lwtt);
        return (src != 5'd0) && (tuse < tnew) && ((src == dst) || lwtt);
    endfunction

    always_comb begin
        stall = hazard(D_A1, D_tuse_rs, e_q.a3, e_q.tnew, e_q.lwtt) ||
                hazard(D_A1, D_tuse_rs, M_A3,   M_tnew,   M_lwtt)   ||
                hazard(D_A2, D_tuse_rt, e_q.a3, e_q.tnew, e_q.lwtt) ||
                hazard(D_A2, D_tuse_rt, M_A3,   M_tnew,   M_lwtt);
    end

    // Bubble keeps only the PC so later stages still see where the hole came from.
    always_comb begin
        e_d = '0;
        if (stall) begin
            e_d.pc = D_pc;
        end else begin
            e_d.instr      = D_instr;
            e_d.pc         = D_pc;
            e_d.rs_data    = D_rs_data;
            e_d.rt_data    = D_rt_data;
            e_d.ext        = D_ext;
            e_d.rf_wr      = D_RfWr;
            e_d.dm_wr      = D_DMWr;
            e_d.alu_op     = D_ALUOp;
            e_d.src_alu_b  = D_Src_ALU_B;
            e_d.rf_wd_type = D_RF_WD_type;
            e_d.load_type  = D_load_type;
            e_d.store_type = D_store_type;
            e_d.a1         = D_A1;
            e_d.a2         = D_A2;
            e_d.a3         = D_A3;
            e_d.tnew       = D_E_tnew;
            e_d.lwtt       = D_lwtt;
            e_d.valid      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) e_q <= '0;
        else        e_q <= e_d;
    end

    assign E_instr      = e_q.instr;
    assign E_pc         = e_q.pc;
    assign E_rs_data    = e_q.rs_data;
    assign E_rt_data    = e_q.rt_data;
    assign E_ext        = e_q.ext;
    assign E_RfWr       = e_q.rf_wr;
    assign E_DMWr       = e_q.dm_wr;
    assign E_ALUOp      = e_q.alu_op;
    assign E_Src_ALU_B  = e_q.src_alu_b;
    assign E_RF_WD_type = e_q.rf_wd_type;
    assign E_load_type  = e_q.load_type;
    assign E_store_type = e_q.store_type;
    assign E_A1         = e_q.a1;
    assign E_A2         = e_q.a2;
    assign E_A3         = e_q.a3;
    assign E_tnew       = e_q.tnew;
    assign E_lwtt       = e_q.lwtt;
    assign E_valid      = e_q.valid;

`ifdef DE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/de_pipe_reg.md
DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-low (0 = reset).
REQ-003 SHALL have inputs D_instr and D_pc (32 each): the decode-stage instruction and its PC.
REQ-004 SHALL have inputs D_rs_data, D_rt_data and D_ext (32 each): the forwarded rs/rt values and the extended immediate.
REQ-005 SHALL have decode-control inputs: D_RfWr(1), D_DMWr(1), D_ALUOp(3), D_Src_ALU_B(3), D_RF_WD_type(2), D_load_type(3), D_store_type(3).
REQ-006 SHALL have hazard inputs: D_A1, D_A2, D_A3 (5 each), D_tuse_rs and D_tuse_rt (2 each), D_E_tnew(2), D_lwtt(1).
REQ-007 SHALL have inputs M_A3(5), M_tnew(2) and M_lwtt(1), describing the instruction currently in the memory stage.
REQ-008 SHALL have output stall(1), combinational: when 1, the PC and the F/D register hold.
REQ-009 SHALL have registered outputs E_instr, E_pc, E_rs_data, E_rt_data, E_ext and every control field above prefixed E_, plus E_A1, E_A2, E_A3, E_tnew(2), E_lwtt(1) and E_valid(1).

Function
REQ-010 Stall SHALL be 1 when any hazard term is true. Term for rs = (D_A1 != 0) and (D_tuse_rs < E_tnew) and (D_A1 == E_A3 or E_lwtt).
REQ-011 An equivalent rs term SHALL use M_tnew, M_A3 and M_lwtt; the rt terms SHALL use the same four forms with D_A2 and D_tuse_rt.
REQ-012 The lwtt terms SHALL be conservative: a producer whose destination is unresolved (lwtt=1) matches any nonzero source register.
REQ-013 The tuse/tnew comparisons SHALL be unsigned 2-bit; tuse=3 means "not used" and never stalls.
REQ-014 Without stall, on each edge, every E_ register SHALL load its D_ counterpart, with E_tnew <= D_E_tnew and E_valid <= 1.
REQ-015 With stall=1, a bubble SHALL be inserted: E_instr, E_RfWr, E_DMWr, E_A1, E_A2, E_A3, E_tnew, E_lwtt, E_store_type, E_load_type and E_valid load 0.
REQ-016 During a bubble E_pc SHALL load D_pc, and the remaining data/control fields SHALL load 0.
REQ-017 Latency SHALL be exactly one cycle from D_ input to E_ output; there is no internal buffering beyond one entry.
REQ-018 A bubble SHALL never stall itself: E_A3=0, E_tnew=0 and E_lwtt=0 guarantee no E term on the next cycle.
REQ-019 When stall persists N cycles, N consecutive bubbles SHALL be issued; the held D instruction SHALL enter E on the first non-stall edge.
REQ-020 When E and M terms fire simultaneously, the result SHALL be a single stall (logical OR); no priority is needed.
REQ-021 Register 0 as destination SHALL never cause a stall, even with a nonzero tnew.

Reset
REQ-022 When reset==0 at an edge, all E_ outputs (including E_pc) SHALL load 0; reset SHALL take priority over stall and capture.
REQ-023 Reset asserted mid-stall SHALL clear E_; stall then depends only on the current inputs, since the E-side terms are 0.
REQ-024 The first edge after reset deasserts SHALL capture normally.

Configuration
REQ-025 When macro DE_STALL_CNT_EN is defined, an output stall_cnt(32) SHALL exist. It resets to 0, increments on each edge where stall=1 and reset=1, and saturates at 32'hFFFFFFFF.
REQ-026 When DE_STALL_CNT_EN is undefined, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-027 Scenario 1 (lw-use): E holds lw with E_A3=5 and E_tnew=2; D has add with A1=5 and tuse_rs=1 -> stall=1 for one cycle; E_instr=0 and E_valid=0 next cycle; add enters E the cycle after.
REQ-028 Scenario 2 (beq after add): E holds add with A3=8 and tnew=1; D has beq with A2=8 and tuse_rt=0 -> stall=1. Next cycle M_A3=8, M_tnew=0 -> stall=0.
REQ-029 Scenario 3 ($0): E holds ori with A3=0 and tnew=1; D has add with A1=0 -> stall=0 and capture proceeds.
REQ-030 Scenario 4 (lwtt): E holds lwie with E_lwtt=1, E_tnew=2 and E_A3=31; D has A1=9 and tuse_rs=1 -> stall=1. With A1=0 -> stall=0.
REQ-031 Scenario 5 (reset mid-stall): assert stall, then reset=0 for one edge -> all E_=0. With DE_STALL_CNT_EN defined, stall_cnt=0.
REQ-032 Scenario 6 (counter): DE_STALL_CNT_EN defined, 3 stall cycles then 2 free cycles -> stall_cnt=3. Preload 32'hFFFFFFFF plus one more stall -> stays 32'hFFFFFFFF.
